prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side partner of the starfield/lfsr generator: serial checker for the
//  bit stream taken from generator sreg[0] (TAPS 21'b1010...0, Galois right-shift).
//  That stream obeys b[n] = b[n-19] ^ b[n-21]. Block self-seeds from incoming bits,
//  locks, then flags and counts mismatches. Sits on video/debug links and in benches
//  to prove pattern integrity across clock/pipeline boundaries.
// PARAMETERS
//  LOCK_CNT    64   consecutive correct predictions in HUNT required to lock (1..1023)
//  UNLOCK_CNT  8    consecutive mismatches in LOCKED that drop lock (1..255)
//  CNT_W       16   width of err_cnt and bit_cnt
// PORTS
//  clk      in   1      clock
//  rst      in   1      synchronous reset, active-high
//  en       in   1      din valid this cycle; nothing advances when low
//  din      in   1      received stream bit
//  clr      in   1      synchronous clear of err_cnt/bit_cnt only; lock state kept
//  locked   out  1      checker in LOCKED state
//  err      out  1      one-cycle pulse: bit accepted in LOCKED mismatched prediction
//  err_cnt  out  CNT_W  mismatches while LOCKED, saturating at all-ones
//  bit_cnt  out  CNT_W  bits checked while LOCKED, saturating at all-ones
// BEHAVIOUR
//  - Reset: state=HUNT, hist=0, fill=0, run=0, locked=0, err=0, err_cnt=0, bit_cnt=0.
//  - hist[20:0]: hist[0] = most recent bit. Prediction p = hist[18] ^ hist[20].
//  - All updates occur only on cycles with en=1; outputs registered, 1-cycle latency.
//  - HUNT: every en shifts din into hist. fill counts 0..21 (saturates at 21). While
//    fill<21 no check. Once fill=21: din==p and hist!=0 -> run++, else run=0.
//    run reaching LOCK_CNT -> LOCKED (locked=1 next cycle), run=0.
//  - All-zero history never counts as a match: constant-0 input never locks.
//  - LOCKED: hist shifts in p (free-running), NOT din, so one flipped bit gives
//    exactly one err. bit_cnt++ each en. din!=p -> err=1 next cycle, err_cnt++,
//    run++; din==p -> run=0. run reaching UNLOCK_CNT -> HUNT: locked=0, fill=0,
//    run=0, hist=0; the bit causing unlock is not re-used for hunting.
//  - err is asserted only for the cycle after the offending en; 0 otherwise,
//    including in HUNT.
//  - Counters saturate at 2^CNT_W-1, never wrap. clr with a same-cycle increment:
//    clr wins (counter=0). rst wins over clr and en.
//  - en=0: all state, counters held; err=0.
//  - rst mid-LOCKED: full return to reset values next cycle; relock needs 21+LOCK_CNT
//    fresh bits.
//  - Lock latency with en=1 continuously from first bit: locked rises the cycle
//    after bit index 20+LOCK_CNT (0-based) is accepted, i.e. 21+LOCK_CNT cycles.
// TESTING
//  - Clean stream from model lfsr (SEED 21'h1FFFFF), en=1 -> locked=1 exactly at
//    cycle 85 (LOCK_CNT=64); err never 1; bit_cnt=1000 after 1000 further bits.
//  - Locked, flip one bit -> single err pulse next cycle, err_cnt=1, locked stays 1.
//  - Locked, invert 8 consecutive bits -> err_cnt=8, locked=0 after 8th; resume
//    clean stream -> relock after 21+64 bits, err_cnt held at 8.
//  - din=0 for 5000 bits -> locked stays 0; din=1 constant also never locks.
//  - en toggled randomly (~50%) on clean stream -> lock after 85 en-cycles, no err;
//    clr pulse -> err_cnt=bit_cnt=0, locked stays 1.
//  - CNT_W=4, stream of inverted bits with UNLOCK_CNT=255 -> err_cnt saturates at
//    15; rst mid-LOCKED -> all outputs 0 next cycle.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial checker for the b[n] = b[n-19] ^ b[n-21] pattern stream: self-seeds from
// incoming bits, locks after a run of correct predictions, then flags and counts errors.
module prbs_checker #(
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned UNLOCK_CNT = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned RUN_W = 10;
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

  typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [20:0]      hist_q, hist_d;
  logic [4:0]       fill_q, fill_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             pred_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign pred_s = hist_q[18] ^ hist_q[20];

  // next-state, history, run length and counter update
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    run_d     = run_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (en) begin
      case (state_q)
        HUNT: begin
          hist_d = {hist_q[19:0], din};
          if (fill_q < 5'd21) begin
            fill_d = fill_q + 5'd1;
          end else if ((din == pred_s) && (hist_q != 21'd0)) begin
            if (run_q == LOCK_LAST) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          // free-run on the prediction so a single flipped bit costs one error
          hist_d    = {hist_q[19:0], pred_s};
          bit_cnt_d = sat_inc(bit_cnt_q);
          if (din != pred_s) begin
            err_d     = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            if (run_q == UNLOCK_LAST) begin
              state_d = HUNT;
              run_d   = '0;
              fill_d  = 5'd0;
              hist_d  = 21'd0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      err_cnt_d = err_cnt_d;
    end
    locked_d = (state_d == LOCKED);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      hist_q    <= 21'd0;
      fill_q    <= 5'd0;
      run_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: stream from a Galois LFSR model, default and
// narrow-counter instances.
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, din, clr;
  logic locked, err;
  logic [15:0] err_cnt, bit_cnt;

  logic rst1, en1, din1, clr1;
  logic locked1, err1;
  logic [3:0] err_cnt1, bit_cnt1;

  prbs_checker dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs_checker #(.LOCK_CNT(64), .UNLOCK_CNT(255), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .din(din1), .clr(clr1),
    .locked(locked1), .err(err1), .err_cnt(err_cnt1), .bit_cnt(bit_cnt1)
  );

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int lock_seen = 0;
  logic [20:0] g;
  logic b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Galois right-shift generator, taps at bits 20 and 18, output from bit 0
  task automatic gen(output logic bo);
    bo = g[0];
    g = g >> 1;
    if (bo) g = g ^ 21'h140000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic bi);
    en = 1'b1;
    din = bi;
    tick();
    if (err) err_seen++;
    if (locked) lock_seen++;
  endtask

  task automatic feed1(input logic bi);
    en1 = 1'b1;
    din1 = bi;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; din1 = 1'b0; clr1 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst1 = 1'b0;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_bit_cnt", {16'd0, bit_cnt}, 32'd0);

    // clean stream: lock exactly after 85 bits
    g = 21'h1FFFFF;
    for (int i = 0; i < 84; i++) begin gen(b); feed(b); end
    chk("lock_at_84", {31'd0, locked}, 32'd0);
    gen(b); feed(b);
    chk("lock_at_85", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 1000; i++) begin gen(b); feed(b); end
    chk("bit_cnt_1000", {16'd0, bit_cnt}, 32'd1000);
    chk("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("clean_err_seen", err_seen, 32'd0);

    // single flipped bit
    gen(b); feed(~b);
    chk("flip_err", {31'd0, err}, 32'd1);
    chk("flip_err_cnt", {16'd0, err_cnt}, 32'd1);
    chk("flip_locked", {31'd0, locked}, 32'd1);
    gen(b); feed(b);
    chk("flip_err_pulse", {31'd0, err}, 32'd0);
    chk("flip_bit_cnt", {16'd0, bit_cnt}, 32'd1002);

    // en low holds everything, even with a wrong bit presented
    en = 1'b0; din = ~din;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_bit_cnt", {16'd0, bit_cnt}, 32'd1002);
    chk("hold_err", {31'd0, err}, 32'd0);

    // clr without en, then clr colliding with an increment
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("clr_locked", {31'd0, locked}, 32'd1);
    clr = 1'b1; gen(b); feed(b); clr = 1'b0;
    chk("clr_wins", {16'd0, bit_cnt}, 32'd0);

    // eight consecutive inverted bits drop lock
    for (int i = 0; i < 7; i++) begin gen(b); feed(~b); end
    chk("inv7_locked", {31'd0, locked}, 32'd1);
    gen(b); feed(~b);
    chk("inv8_unlocked", {31'd0, locked}, 32'd0);
    chk("inv8_err_cnt", {16'd0, err_cnt}, 32'd8);
    chk("inv8_bit_cnt", {16'd0, bit_cnt}, 32'd8);
    for (int i = 0; i < 84; i++) begin gen(b); feed(b); end
    chk("relock_84", {31'd0, locked}, 32'd0);
    gen(b); feed(b);
    chk("relock_85", {31'd0, locked}, 32'd1);
    chk("relock_err_cnt", {16'd0, err_cnt}, 32'd8);

    // constant inputs never lock
    rst = 1'b1; tick(); rst = 1'b0;
    lock_seen = 0;
    for (int i = 0; i < 5000; i++) feed(1'b0);
    for (int i = 0; i < 500; i++) feed(1'b1);
    chk("const_no_lock", lock_seen, 32'd0);

    // random en on a clean stream: lock after 85 accepted bits
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    err_seen = 0;
    g = 21'h1FFFFF;
    begin
      int n_en = 0;
      for (int c = 0; c < 2000 && n_en < 85; c++) begin
        if ($urandom_range(1, 0) == 1) begin
          gen(b); feed(b); n_en++;
          if (n_en == 84) chk("rnd_lock_84", {31'd0, locked}, 32'd0);
          if (n_en == 85) chk("rnd_lock_85", {31'd0, locked}, 32'd1);
        end else begin
          en = 1'b0; din = $urandom_range(1, 0) == 1; tick();
          if (err) err_seen++;
        end
      end
      chk("rnd_en_count", n_en, 32'd85);
    end
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(1, 0) == 1) begin gen(b); feed(b); end
      else begin en = 1'b0; tick(); end
    end
    chk("rnd_err_seen", err_seen, 32'd0);
    en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    chk("rnd_clr_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    chk("rnd_clr_locked", {31'd0, locked}, 32'd1);

    // narrow counters saturate; reset while locked clears everything
    g = 21'h1FFFFF;
    for (int i = 0; i < 85; i++) begin gen(b); feed1(b); end
    chk("n_locked", {31'd0, locked1}, 32'd1);
    for (int i = 0; i < 20; i++) begin gen(b); feed1(~b); end
    chk("n_err_sat", {28'd0, err_cnt1}, 32'd15);
    chk("n_bit_sat", {28'd0, bit_cnt1}, 32'd15);
    chk("n_still_locked", {31'd0, locked1}, 32'd1);
    rst1 = 1'b1; gen(b); feed1(~b); rst1 = 1'b0; en1 = 1'b0;
    chk("n_rst_locked", {31'd0, locked1}, 32'd0);
    chk("n_rst_err", {31'd0, err1}, 32'd0);
    chk("n_rst_err_cnt", {28'd0, err_cnt1}, 32'd0);
    chk("n_rst_bit_cnt", {28'd0, bit_cnt1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
